// File: rtl/bf_delay_ctrl.sv
// Sequencer for one radix-2 SDF butterfly stage: FILL / BFLY / DRAIN over 2*DELAY_LENGTH blocks.
// Strobes are combinational from state and inputs; bf_en/bf_sel/out_valid/done lag fifo_read by 1 cycle.
// Backpressure: in_ready drops on fifo_full in FILL and on fifo_empty in BFLY; DRAIN never stalls.
module bf_delay_ctrl #(
  parameter int DELAY_LENGTH = 16,
  parameter int CNT_W        = $clog2(DELAY_LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             fifo_write,
  output logic             fifo_read,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             bf_en,
  output logic             bf_sel,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BFLY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY_LENGTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_set;
  logic             last_read;
  logic             at_last;

  assign at_last = (blk_cnt == LAST);

  // State and block counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      blk_cnt <= '0;
    end else begin
      state   <= state_nxt;
      blk_cnt <= cnt_nxt;
    end
  end

  // Next-state and counter: advance only on accepted blocks (FILL/BFLY) or reads (DRAIN)
  always_comb begin
    state_nxt = state;
    cnt_nxt   = blk_cnt;
    case (state)
      IDLE: begin
        if (start && fifo_empty) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
      end
      FILL: begin
        if (fifo_write) begin
          if (at_last) begin
            state_nxt = BFLY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = blk_cnt + CNT_W'(1);
          end
        end
      end
      BFLY: begin
        if (fifo_read) begin
          if (at_last) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = blk_cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (fifo_read && !at_last) begin
          cnt_nxt = blk_cnt + CNT_W'(1);
        end else begin
          // Either the final read or an underrun: both end the frame
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Combinational handshake, strobes and protocol-error detection
  always_comb begin
    in_ready   = 1'b0;
    fifo_write = 1'b0;
    fifo_read  = 1'b0;
    err_set    = 1'b0;
    case (state)
      FILL: begin
        in_ready   = !fifo_full;
        fifo_write = in_valid && !fifo_full;
        err_set    = in_valid && fifo_full;
      end
      BFLY: begin
        // Read and write together keep the delay line at DELAY_LENGTH entries
        in_ready   = !fifo_empty;
        fifo_write = in_valid && !fifo_empty;
        fifo_read  = in_valid && !fifo_empty;
        err_set    = in_valid && fifo_empty;
      end
      DRAIN: begin
        fifo_read = !fifo_empty;
        err_set   = fifo_empty;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign last_read = (state == DRAIN) && fifo_read && at_last;

  // Output flags follow the delay-line read by one cycle to match its registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      bf_en     <= 1'b0;
      bf_sel    <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      bf_en     <= fifo_read;
      bf_sel    <= fifo_read && (state == DRAIN);
      out_valid <= fifo_read;
      done      <= last_read;
      err       <= err || err_set;
    end
  end

endmodule

// File: tb/tb_bf_delay_ctrl.sv
// Directed testbench for bf_delay_ctrl with a behavioural delay-line occupancy model.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// Delay-line full/empty can be overridden to provoke protocol errors.
module tb_bf_delay_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       fifo_write;
  logic       fifo_read;
  logic       fifo_full;
  logic       fifo_empty;
  logic       bf_en;
  logic       bf_sel;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] blk_cnt;

  int  pass_cnt;
  int  total_cnt;
  int  occ;
  bit  force_full;
  bit  force_nonempty;
  bit  fifo_clr;

  int  r_wo, r_rw, r_dr, r_ov, r_sel0, r_sel1, r_done, r_align;
  int  r_idlew, r_blk10, r_busy0, r_err, r_bfmis;

  bf_delay_ctrl #(.DELAY_LENGTH(16), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fifo_write (fifo_write),
    .fifo_read  (fifo_read),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .bf_en      (bf_en),
    .bf_sel     (bf_sel),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .blk_cnt    (blk_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Delay-line occupancy model standing in for the 16-deep shift_reg
  always @(posedge clk) begin
    if (fifo_clr) occ <= 0;
    else occ <= occ + (fifo_write ? 1 : 0) - (fifo_read ? 1 : 0);
  end

  assign fifo_full  = force_full || (occ == 16);
  assign fifo_empty = (occ == 0) && !force_nonempty;

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one frame and tallies strobes/outputs until done (bounded at 200 cycles)
  task automatic run_frame(input bit toggle, input bit started);
    bit seen;
    r_wo = 0; r_rw = 0; r_dr = 0; r_ov = 0; r_sel0 = 0; r_sel1 = 0; r_done = 0;
    r_align = 0; r_idlew = 0; r_blk10 = -1; r_busy0 = -1; r_err = -1; r_bfmis = 0;
    seen = 1'b0;
    if (!started) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = toggle ? ((i % 2) == 0) : 1'b1;
      #1;
      if (i == 0)  r_busy0 = int'(busy);
      if (i == 10) r_blk10 = int'(blk_cnt);
      if (fifo_write && !fifo_read) r_wo++;
      if (fifo_write && fifo_read)  r_rw++;
      if (!fifo_write && fifo_read) r_dr++;
      if (fifo_write && !in_valid)  r_idlew++;
      if (bf_en !== out_valid)      r_bfmis++;
      if (out_valid) begin
        r_ov++;
        if (r_ov <= 16 && bf_sel == 1'b0) r_sel0++;
        if (r_ov > 16 && bf_sel == 1'b1)  r_sel1++;
      end
      if (done) begin
        r_done++;
        if (out_valid && r_ov == 32) r_align = 1;
        seen = 1'b1;
      end
    end
    in_valid = 1'b0;
    r_err = int'(err);
  endtask

  task automatic test_reset();
    do_rst();
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (blk_cnt !== 4'd0) $display("FAIL reset_blk got %0d want 0", blk_cnt); else pass_cnt++;
    total_cnt++; if ({bf_en, bf_sel, out_valid, done, err} !== 5'b0)
      $display("FAIL reset_regs got %b want 00000", {bf_en, bf_sel, out_valid, done, err}); else pass_cnt++;
    total_cnt++; if ({in_ready, fifo_write, fifo_read} !== 3'b0)
      $display("FAIL reset_strobes got %b want 000", {in_ready, fifo_write, fifo_read}); else pass_cnt++;
  endtask

  task automatic test_frame();
    do_rst();
    run_frame(1'b0, 1'b0);
    total_cnt++; if (r_busy0 != 1)  $display("FAIL frame_busy got %0d want 1", r_busy0); else pass_cnt++;
    total_cnt++; if (r_wo != 16)    $display("FAIL frame_write_only got %0d want 16", r_wo); else pass_cnt++;
    total_cnt++; if (r_rw != 16)    $display("FAIL frame_read_write got %0d want 16", r_rw); else pass_cnt++;
    total_cnt++; if (r_dr != 16)    $display("FAIL frame_drain_reads got %0d want 16", r_dr); else pass_cnt++;
    total_cnt++; if (r_ov != 32)    $display("FAIL frame_out_valid got %0d want 32", r_ov); else pass_cnt++;
    total_cnt++; if (r_sel0 != 16)  $display("FAIL frame_sel0_first16 got %0d want 16", r_sel0); else pass_cnt++;
    total_cnt++; if (r_sel1 != 16)  $display("FAIL frame_sel1_last16 got %0d want 16", r_sel1); else pass_cnt++;
    total_cnt++; if (r_done != 1)   $display("FAIL frame_done_count got %0d want 1", r_done); else pass_cnt++;
    total_cnt++; if (r_align != 1)  $display("FAIL frame_done_align got %0d want 1", r_align); else pass_cnt++;
    total_cnt++; if (r_err != 0)    $display("FAIL frame_err got %0d want 0", r_err); else pass_cnt++;
    total_cnt++; if (r_blk10 != 10) $display("FAIL frame_blk10 got %0d want 10", r_blk10); else pass_cnt++;
    total_cnt++; if (r_bfmis != 0)  $display("FAIL frame_bf_en_eq got %0d want 0", r_bfmis); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL frame_idle_at_done got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_rst();
    run_frame(1'b1, 1'b0);
    total_cnt++; if (r_blk10 != 5)  $display("FAIL stall_blk10 got %0d want 5", r_blk10); else pass_cnt++;
    total_cnt++; if (r_idlew != 0)  $display("FAIL stall_idle_write got %0d want 0", r_idlew); else pass_cnt++;
    total_cnt++; if (r_wo != 16)    $display("FAIL stall_write_only got %0d want 16", r_wo); else pass_cnt++;
    total_cnt++; if (r_rw != 16)    $display("FAIL stall_read_write got %0d want 16", r_rw); else pass_cnt++;
    total_cnt++; if (r_ov != 32)    $display("FAIL stall_out_valid got %0d want 32", r_ov); else pass_cnt++;
    total_cnt++; if (r_done != 1)   $display("FAIL stall_done got %0d want 1", r_done); else pass_cnt++;
    total_cnt++; if (r_err != 0)    $display("FAIL stall_err got %0d want 0", r_err); else pass_cnt++;
  endtask

  task automatic test_start_blocked();
    do_rst();
    force_nonempty = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL blocked_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (err !== 1'b0)  $display("FAIL blocked_err got %0b want 0", err); else pass_cnt++;
    force_nonempty = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b1)     $display("FAIL unblocked_busy got %0b want 1", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL unblocked_fill_ready got %0b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_full_err();
    do_rst();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; force_full = 1'b1; in_valid = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b0)   $display("FAIL full_in_ready got %0b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (fifo_write !== 1'b0) $display("FAIL full_write got %0b want 0", fifo_write); else pass_cnt++;
    @(negedge clk); force_full = 1'b0; in_valid = 1'b0;
    #1;
    total_cnt++; if (err !== 1'b1) $display("FAIL full_err_set got %0b want 1", err); else pass_cnt++;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++; if (err !== 1'b1) $display("FAIL full_err_sticky got %0b want 1", err); else pass_cnt++;
    do_rst();
    #1;
    total_cnt++; if (err !== 1'b0) $display("FAIL full_err_cleared got %0b want 0", err); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_rst();
    @(negedge clk); start = 1'b1;
    repeat (23) begin
      @(negedge clk); start = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    #1;
    total_cnt++; if (blk_cnt !== 4'd7)   $display("FAIL mid_blk7 got %0d want 7", blk_cnt); else pass_cnt++;
    total_cnt++; if (fifo_read !== 1'b1) $display("FAIL mid_bfly_read got %0b want 1", fifo_read); else pass_cnt++;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0)    $display("FAIL mid_rst_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (blk_cnt !== 4'd0) $display("FAIL mid_rst_blk got %0d want 0", blk_cnt); else pass_cnt++;
    total_cnt++; if ({out_valid, done, err} !== 3'b0)
      $display("FAIL mid_rst_regs got %b want 000", {out_valid, done, err}); else pass_cnt++;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_holdoff got %0b want 0", busy); else pass_cnt++;
    fifo_clr = 1'b1;
    @(negedge clk); fifo_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_rst();
    run_frame(1'b0, 1'b0);
    total_cnt++; if (r_done != 1) $display("FAIL b2b_first_done got %0d want 1", r_done); else pass_cnt++;
    start = 1'b1;
    run_frame(1'b0, 1'b1);
    total_cnt++; if (r_busy0 != 1) $display("FAIL b2b_busy_next got %0d want 1", r_busy0); else pass_cnt++;
    total_cnt++; if (r_wo != 16 || r_rw != 16 || r_dr != 16)
      $display("FAIL b2b_strobes got %0d/%0d/%0d want 16/16/16", r_wo, r_rw, r_dr); else pass_cnt++;
    total_cnt++; if (r_ov != 32 || r_sel0 != 16 || r_sel1 != 16)
      $display("FAIL b2b_outputs got %0d/%0d/%0d want 32/16/16", r_ov, r_sel0, r_sel1); else pass_cnt++;
    total_cnt++; if (r_done != 1 || r_align != 1)
      $display("FAIL b2b_done got %0d/%0d want 1/1", r_done, r_align); else pass_cnt++;
    total_cnt++; if (r_err != 0) $display("FAIL b2b_err got %0d want 0", r_err); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    force_full = 1'b0; force_nonempty = 1'b0; fifo_clr = 1'b1; occ = 0;
    @(negedge clk); fifo_clr = 1'b0;
    test_reset();
    test_frame();
    test_stall();
    test_start_blocked();
    test_full_err();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
